// File: rtl/key_scan_ctrl.sv
// Keypad front end: it synchronises 10 active-low key lines, priority-encodes
// them and debounces press and release. Each accepted press is queued in a
// small FWFT FIFO that the consumer drains with valid/ready.
module key_scan_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             S_n,
  input  logic                   key_ready,
  input  logic                   ovf_clr,
  output logic [3:0]             key_code,
  output logic                   key_valid,
  output logic                   key_held,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEB_C = (CW+1)'(DEB_CYCLES);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam bit DEB1 = (DEB_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [9:0]    s1, s2;
  logic          any;
  logic [3:0]    code;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    cand, cand_nx;
  logic [CW:0]   cnt_inc;
  logic          deb_done, push;
  logic [3:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, pop, wr_en, ovf_set;

  // Two-flop synchroniser. Its reset value means all keys are released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= S_n;
      s2 <= s1;
    end
  end

  // Priority encoder. The ascending scan lets the highest pressed key win.
  always_comb begin
    any  = 1'b0;
    code = '0;
    for (int i = 0; i < 10; i++) begin
      if (!s2[i]) begin
        any  = 1'b1;
        code = 4'(i);
      end
    end
  end

  assign cnt_inc  = {1'b0, cnt} + (CW+1)'(1);
  assign deb_done = (cnt_inc >= DEB_C);

  // Debounce FSM state, sample counter and candidate code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

  // Next state. A push fires on the edge at which the press debounce completes.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          cand_nx = code;
          if (DEB1) begin
            push     = 1'b1;
            state_nx = HELD;
            cnt_nx   = '0;
          end else begin
            state_nx = PRESS_DB;
            cnt_nx   = CW'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!any) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (code != cand) begin
          cand_nx = code;
          cnt_nx  = CW'(1);
        end else if (deb_done) begin
          push     = 1'b1;
          state_nx = HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc[CW-1:0];
        end
      end
      HELD: begin
        if (!any || code != cand) begin
          // With a one-sample debounce, the release sample completes the release at once.
          if (!any && DEB1) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = RELEASE_DB;
            cnt_nx   = any ? CW'(0) : CW'(1);
          end
        end
      end
      RELEASE_DB: begin
        if (any) begin
          cnt_nx = '0;
        end else if (deb_done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc[CW-1:0];
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign key_held  = (state == HELD);

  assign fifo_cnt  = wptr - rptr;
  assign full      = (fifo_cnt == DEPTH_C);
  assign key_valid = (wptr != rptr);
  assign pop       = key_valid & key_ready;
  assign wr_en     = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign key_code  = key_valid ? mem[rptr[AW-1:0]] : 4'd0;

  // FIFO pointers. The extra MSB tells full apart from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (pop)   rptr <= rptr + (AW+1)'(1);
    end
  end

  // Event storage. It needs no reset because key_code is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= code;
  end

  // Sticky overflow flag. A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule
